// File: rtl/bram_port_arbiter_pkg.sv
// bram_port_arbiter_pkg: arbitration modes and BRAM geometry shared with bram16
package bram_port_arbiter_pkg;
   localparam int PRIO_RR         = 0;
   localparam int PRIO_FIXED      = 1;
   localparam int BRAM_ADDR_WIDTH = 9;
   localparam int BRAM_DATA_WIDTH = 16;
   function automatic int wrap_idx(input int i, input int n);
      return i % n;
   endfunction
endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational one-hot grant with a round-robin pointer or fixed priority
module rr_arbiter
   import bram_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int PRIO_MODE = PRIO_RR
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt
);
   localparam int PW = $clog2(NUM_REQ);
   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] idx;
   // Scan from lowest to highest priority so the last hit is the winner
   always_comb begin
      gnt = '0;
      win = ptr;
      idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (PRIO_MODE == PRIO_FIXED) ? PW'(k - 1) : PW'(wrap_idx(int'(ptr) + k, NUM_REQ));
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            win      = idx;
         end
      end
      if (!rst_n) gnt = '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= PW'(NUM_REQ - 1);
      else if (|gnt && PRIO_MODE == PRIO_RR) ptr <= win;
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one bram16 port among NUM_REQ requesters with tagged read return
module bram_port_arbiter
   import bram_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
   parameter int PRIO_MODE  = PRIO_RR
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rvalid,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_din,
   input  logic [DATA_WIDTH-1:0]         mem_dout,
   output logic                          busy
);
   logic [NUM_REQ-1:0]    tag1;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_din;
   rr_arbiter #(.NUM_REQ(NUM_REQ), .PRIO_MODE(PRIO_MODE)) u_arb (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt)
   );
   always_comb begin
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_din  = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (gnt[i]) begin
            sel_we   = we[i];
            sel_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_din  = wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
   end
   // Address and write data hold across idle cycles; only en/we drop
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         tag1     <= '0;
         rvalid   <= '0;
      end else begin
         mem_en <= |gnt;
         mem_we <= sel_we;
         if (|gnt) begin
            mem_addr <= sel_addr;
            mem_din  <= sel_din;
         end
         tag1   <= gnt & ~we;
         rvalid <= tag1;
      end
   assign rdata = mem_dout;
   assign busy  = |tag1 | |rvalid;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed scoreboard bench driving a round-robin and a fixed-priority instance
module tb_bram_port_arbiter;
   import bram_port_arbiter_pkg::*;
   typedef struct {
      int          idx;
      logic [15:0] data;
      int          due;
   } ent_t;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req, we;
   logic [17:0] addr;
   logic [31:0] wdata;
   logic [1:0]  gnt [2];
   logic [1:0]  rvalid [2];
   logic [15:0] rdata [2];
   logic        mem_en [2];
   logic        mem_we [2];
   logic [8:0]  mem_addr [2];
   logic [15:0] mem_din [2];
   logic [15:0] mem_dout [2];
   logic        busy [2];
   logic [15:0] bram [2][512];
   logic [15:0] sm [2][512];
   logic        e_en [2];
   logic        e_we [2];
   logic [8:0]  e_addr [2];
   logic [15:0] e_din [2];
   logic [7:0]  seq [2];
   ent_t        q0[$], q1[$];
   int          ptr_m;
   int          cyc = 0;
   int          checks = 0, failures = 0;
   logic [1:0]  p_hold, p_we;
   logic [17:0] p_addr;
   logic [31:0] p_wd;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bram_port_arbiter #(.NUM_REQ(2), .PRIO_MODE(PRIO_RR)) dut_rr (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
      .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_dout(mem_dout[0]), .busy(busy[0])
   );
   bram_port_arbiter #(.NUM_REQ(2), .PRIO_MODE(PRIO_FIXED)) dut_fx (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
      .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_dout(mem_dout[1]), .busy(busy[1])
   );

   // bram16 behaviour: registered read, read-first on a same-address write
   always @(posedge clk)
      for (int d = 0; d < 2; d++)
         if (mem_en[d]) begin
            if (mem_we[d]) bram[d][mem_addr[d]] <= mem_din[d];
            mem_dout[d] <= bram[d][mem_addr[d]];
         end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [1:0] model_gnt(input logic [1:0] r, input int p, input bit fixed);
      if (r == 2'b00) return 2'b00;
      if (fixed) return r[0] ? 2'b01 : 2'b10;
      for (int k = 1; k <= 2; k++)
         if (r[(p + k) % 2]) return ((p + k) % 2 == 0) ? 2'b01 : 2'b10;
      return 2'b00;
   endfunction

   task automatic push(input int d, input ent_t e);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic predict(input int d, input logic [1:0] g);
      ent_t e;
      e_en[d] = |g;
      e_we[d] = 1'b0;
      for (int i = 0; i < 2; i++)
         if (g[i]) begin
            e_we[d]   = we[i];
            e_addr[d] = addr[i*9 +: 9];
            e_din[d]  = wdata[i*16 +: 16];
            if (we[i]) sm[d][addr[i*9 +: 9]] = wdata[i*16 +: 16];
            else begin
               e.idx  = i;
               e.data = sm[d][addr[i*9 +: 9]];
               e.due  = cyc + 2;
               push(d, e);
            end
         end
   endtask

   task automatic set_req(input int i, input logic r, input logic w, input logic [8:0] a, input logic [15:0] dt);
      req[i] = r;
      we[i]  = w;
      addr[i*9 +: 9]   = a;
      wdata[i*16 +: 16] = dt;
   endtask

   task automatic step();
      logic [1:0] gr, gf;
      #1;
      gr = rst_n ? model_gnt(req, ptr_m, 1'b0) : 2'b00;
      gf = rst_n ? model_gnt(req, 0, 1'b1) : 2'b00;
      chk("gnt_rr", 32'(gnt[0]), 32'(gr));
      chk("gnt_fx", 32'(gnt[1]), 32'(gf));
      seq[0] = {seq[0][5:0], gnt[0]};
      seq[1] = {seq[1][5:0], gnt[1]};
      predict(0, gr);
      predict(1, gf);
      if (gr[0]) ptr_m = 0;
      else if (gr[1]) ptr_m = 1;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("mem_en%0d", d), 32'(mem_en[d]), 32'(e_en[d]));
         chk($sformatf("mem_we%0d", d), 32'(mem_we[d]), 32'(e_we[d]));
         chk($sformatf("mem_addr%0d", d), 32'(mem_addr[d]), 32'(e_addr[d]));
         if (e_we[d]) chk($sformatf("mem_din%0d", d), 32'(mem_din[d]), 32'(e_din[d]));
      end
   endtask

   task automatic idle(input int n);
      req = 2'b00;
      repeat (n) step();
   endtask

   // Asserts reset immediately; in-flight reads and the command must vanish at once
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_mem_en%0d", d), 32'(mem_en[d]), 32'd0);
         chk($sformatf("rst_rvalid%0d", d), 32'(rvalid[d]), 32'd0);
         chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
         chk($sformatf("rst_gnt%0d", d), 32'(gnt[d]), 32'd0);
         e_en[d] = 1'b0; e_we[d] = 1'b0; e_addr[d] = '0; e_din[d] = '0;
      end
      q0.delete();
      q1.delete();
      ptr_m = 1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic mon(input int d);
      ent_t e;
      bit   have;
      have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) e = (d == 0) ? q0[0] : q1[0];
      chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(have && e.due <= cyc + 1));
      if (have && e.due <= cyc) begin
         chk($sformatf("rvalid%0d", d), 32'(rvalid[d]), (e.idx == 0) ? 32'd1 : 32'd2);
         chk($sformatf("rdata%0d", d), 32'(rdata[d]), 32'(e.data));
         if (d == 0) void'(q0.pop_front());
         else void'(q1.pop_front());
      end else chk($sformatf("rvalid_idle%0d", d), 32'(rvalid[d]), 32'd0);
   endtask

   always @(negedge clk)
      if (rst_n === 1'b1) begin
         mon(0);
         mon(1);
      end

   // Requester contract: fields stay put while a request waits for its grant
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         if (p_hold[i] === 1'b1 && req[i])
            chk($sformatf("hold%0d", i), {6'd0, we[i], addr[i*9 +: 9], wdata[i*16 +: 16]},
                {6'd0, p_we[i], p_addr[i*9 +: 9], p_wd[i*16 +: 16]});
      p_hold <= (rst_n === 1'b1) ? (req & ~gnt[0]) : 2'b00;
      p_we   <= we;
      p_addr <= addr;
      p_wd   <= wdata;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b1; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
      seq[0] = '0; seq[1] = '0;
      #1;
      req = 2'b11;
      do_reset();
      req = 2'b00;
      // Preload through requester 0
      set_req(0, 1'b1, 1'b1, 9'h005, 16'hBEEF); step();
      set_req(0, 1'b1, 1'b1, 9'h010, 16'h1010); step();
      set_req(0, 1'b1, 1'b1, 9'h020, 16'h2020); step();
      idle(1);
      // Single read
      set_req(0, 1'b1, 1'b0, 9'h005, 16'h0); step();
      idle(3);
      // Contention: round-robin alternates, fixed priority starves requester 1
      set_req(0, 1'b1, 1'b0, 9'h010, 16'h0);
      set_req(1, 1'b1, 1'b0, 9'h020, 16'h0);
      do_reset();
      seq[0] = '0; seq[1] = '0;
      repeat (4) step();
      chk("rr_order", 32'(seq[0]), 32'h66);
      chk("fx_order", 32'(seq[1]), 32'h55);
      req[0] = 1'b0; step();
      idle(3);
      // Write at top address then read it back
      set_req(1, 1'b1, 1'b1, 9'h1FF, 16'h1234); step();
      set_req(1, 1'b0, 1'b0, 9'h000, 16'h0);
      set_req(0, 1'b1, 1'b0, 9'h1FF, 16'h0); step();
      idle(3);
      // Reset one cycle after a read is accepted
      set_req(0, 1'b1, 1'b0, 9'h005, 16'h0); step();
      req = 2'b00;
      chk("busy_pre_rst", 32'(busy[0]), 32'd1);
      chk("mem_en_pre_rst", 32'(mem_en[0]), 32'd1);
      do_reset();
      set_req(0, 1'b1, 1'b0, 9'h010, 16'h0);
      set_req(1, 1'b1, 1'b0, 9'h020, 16'h0);
      #1;
      chk("post_rst_gnt", 32'(gnt[0]), 32'd1);
      step();
      idle(3);
      // Withdrawn request while requester 0 holds priority
      set_req(0, 1'b1, 1'b0, 9'h010, 16'h0); step();
      req[1] = 1'b1; step();
      step();
      req[1] = 1'b0; step();
      idle(3);
      // Request raised and withdrawn within one cycle leaves the pointer alone
      set_req(1, 1'b1, 1'b0, 9'h020, 16'h0);
      #1;
      chk("rr_peek", 32'(gnt[0]), 32'd2);
      req = 2'b00;
      step();
      req = 2'b11; step();
      step();
      idle(4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of the 16-bit x 512 true dual-port BRAM (`bram16`) among NUM_REQ independent requesters, for example the test FSM plus a debug/loader engine.
- Grant is combinational. The BRAM command is registered, and read data is returned to the originating requester with a tagged rvalid strobe.
- Sits between the requesters and `bram16` port A or B, on the same clock as the BRAM.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_WIDTH, 9, BRAM address width (512 words).
- DATA_WIDTH, 16, BRAM data width.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (index 0 highest).

Ports:
- clk  in  1  single clock; same clock as `bram16`.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester access request; held with fields stable until granted.
- we  in  NUM_REQ  per-requester write flag (1 = write, 0 = read).
- addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses slice [i*AW +: AW].
- wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- gnt  out  NUM_REQ  one-hot/zero accept; the request is consumed at the clock edge where req[i]&gnt[i]=1.
- rvalid  out  NUM_REQ  one-hot read-return strobe.
- rdata  out  DATA_WIDTH  read data, shared by all requesters; valid only with rvalid.
- mem_en  out  1  to BRAM en.
- mem_we  out  1  to BRAM we.
- mem_addr  out  ADDR_WIDTH  to BRAM addr.
- mem_din  out  DATA_WIDTH  to BRAM din.
- mem_dout  in  DATA_WIDTH  from BRAM dout; one-cycle registered read.
- busy  out  1  high while any read is outstanding in the pipeline.

Behaviour:
- Reset is asynchronous on rst_n low and clears:
  - mem_en, mem_we, mem_addr, mem_din, rvalid, busy, tag pipeline → 0;
  - round-robin pointer → NUM_REQ-1, so requester 0 wins first.
- gnt is combinational from req and the pointer, and is 0 during reset.
- Arbitration:
  - Round-robin: search starts at pointer+1 mod NUM_REQ; the first set req wins; pointer ← winner at the edge.
  - Fixed priority (PRIO_MODE=1): lowest set index wins; pointer unused.
  - At most one gnt bit per cycle. gnt=0 when req=0.
- Command stage, latched at the accept edge E0:
  - mem_en ← |gnt.
  - mem_we, mem_addr, mem_din ← winner's fields.
  - If no grant: mem_en ← 0, mem_we ← 0, addr/din hold their previous values.
- Tag pipeline:
  - tag1 ← gnt & ~we at E0.
  - rvalid ← tag1 at E1.
  - rdata = mem_dout, combinational pass-through.
- Read latency: rvalid is high in the cycle after E1, i.e. 2 edges after accept.
- Writes produce no rvalid.
- Throughput: one access per cycle, back-to-back, with no bubbles.
- busy = |tag1 | |rvalid.
- Round-robin fairness: with k requesters continuously requesting, each is granted exactly once every k cycles.
- Requester contract: must not change addr/we/wdata while req=1 and gnt=0. The arbiter does not check this; the bench asserts it.
- Read-after-write to the same address, back-to-back: ordering follows grant order. Returned data follows `bram16` read-during-write semantics; nothing is forwarded.
- Reset asserted mid-operation: in-flight reads are dropped (no rvalid) and the command is squashed (mem_en=0) immediately and asynchronously.
- Reset deassertion: the first grant may occur in the first cycle after rst_n rises.
- req dropped before grant: this is allowed; the request is withdrawn and no state changes.

Decomposition:
- Shared header/package holds PRIO_RR=0 and PRIO_FIXED=1 constants, plus the default ADDR_WIDTH=9 and DATA_WIDTH=16 shared with `bram16`.
- One sub-module, `rr_arbiter`: combinational grant plus the pointer register, parameterised by NUM_REQ and PRIO_MODE.
- The top block holds the command register, tag pipeline and slice muxing.

Test Plan:
1. Single read:
   - Preload addr 0x005 = 0xBEEF; req0=1, we0=0, addr0=0x005.
   - gnt0 in the same cycle; mem_en=1, mem_addr=0x005 one cycle later; rvalid0=1 with rdata=0xBEEF two edges after accept; rvalid1 stays 0.
2. Contention, round-robin:
   - req0 and req1 held high, reads to 0x010 and 0x020.
   - Grants after reset: 0, 1, 0, 1. rvalid alternates 0, 1, 0, 1 with matching data. No idle cycle on mem_en.
3. Fixed priority (PRIO_MODE=1):
   - Same stimulus as scenario 2.
   - req0 is granted every cycle; req1 is granted only once req0 drops.
4. Write then read:
   - Requester 1 writes 0x1234 to 0x1FF (gnt1, mem_we=1, no rvalid).
   - Next cycle requester 0 reads 0x1FF; rvalid0 returns 0x1234.
   - Address 0x1FF confirms the top of the 9-bit address space.
5. Reset mid-operation:
   - Assert rst_n=0 one cycle after a read is accepted.
   - mem_en, rvalid, busy go 0 immediately. After release, no stale rvalid; the next grant goes to requester 0.
6. Withdrawn request:
   - req1 raised while requester 0 is continuously granted (fixed mode), then dropped before being granted.
   - No gnt1 or rvalid1 is ever produced, and the pointer is unchanged.
